chip8_fetch: RTL and testbench
==============================

CHIP8_FETCH -- requirements
Module: chip8_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning memory byte-address width (4 KB CHIP-8 space).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fetch_req  input  1  request to fetch the opcode at pc_in.
REQ-005 SHALL have port pc_in  input  ADDR_W  byte address of opcode high byte.
REQ-006 SHALL have port fetch_ready  output  1  high only in IDLE; request accepted when fetch_req && fetch_ready.
REQ-007 SHALL have port flush  input  1  abort any in-flight or presented fetch.
REQ-008 SHALL have port mem_addr  output  ADDR_W  byte address to the 1-cycle registered-read memory.
REQ-009 SHALL have port mem_we  output  1  memory write enable; constant 0.
REQ-010 SHALL have port mem_wdata  output  8  memory write data; constant 8'h00.
REQ-011 SHALL have port mem_rdata  input  8  memory read data, valid one clock after the address is sampled.
REQ-012 SHALL have port op_valid  output  1  opcode/decode outputs valid.
REQ-013 SHALL have port op_ready  input  1  consumer accepts the opcode when op_valid && op_ready.
REQ-014 SHALL have port opcode  output  16  {high byte, low byte}, big-endian.
REQ-015 SHALL have port op_pc / next_pc  output  ADDR_W each  fetched address; (op_pc+2) mod 2^ADDR_W.
REQ-016 SHALL have port dec_x, dec_y, dec_n  output  4 each  opcode[11:8], [7:4], [3:0].
REQ-017 SHALL have port dec_nn / dec_nnn  output  8 / 12  opcode[7:0], opcode[11:0].
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, REQ_HI, REQ_LO, CAP_LO, VALID.
REQ-020 SHALL, in IDLE on fetch_req && !flush, latch pc_reg <= pc_in and go to REQ_HI.
REQ-021 SHALL drive mem_addr = pc_reg in REQ_HI and IDLE, and (pc_reg+1) mod 2^ADDR_W in REQ_LO and CAP_LO.
REQ-022 SHALL transition REQ_HI -> REQ_LO unconditionally.
REQ-023 SHALL, on REQ_LO -> CAP_LO, capture hi_byte <= mem_rdata (= mem[pc]).
REQ-024 SHALL, on CAP_LO -> VALID, capture lo_byte <= mem_rdata (= mem[pc+1]).
REQ-025 SHALL yield latency: request accepted at edge k -> op_valid high from edge k+3.
REQ-026 SHALL, in VALID, hold op_valid and all outputs stable until op_ready; on op_valid && op_ready, go to IDLE (op_valid low the next cycle).
REQ-027 SHALL drive all decode fields combinationally from the registered opcode; they are don't-care when op_valid=0.
REQ-028 SHALL wrap addresses modulo 2^ADDR_W: pc_in=0xFFF reads low byte from 0x000, and next_pc=0x001.
REQ-029 SHALL accept odd pc_in without error.
REQ-030 SHALL, on flush in any state, go to IDLE at the next edge and drop op_valid; flush overrides fetch_req and op_ready in the same cycle.
REQ-031 SHALL ignore fetch_req outside IDLE; a new request is accepted no earlier than the cycle after a handshake.
REQ-032 SHALL never assert mem_we.

Reset
REQ-033 SHALL, with rst high at an edge, force state IDLE, pc_reg=0, opcode=16'h0000, op_valid=0, busy=0, fetch_ready=1 (after release).
REQ-034 SHALL have rst override flush and all other inputs; rst mid-fetch discards partial bytes.

Verification
REQ-035 SHALL cover basic fetch: mem[0x200]=12, mem[0x201]=34, fetch pc 0x200 -> op_valid at edge k+3; opcode 1234, dec_nnn 234, next_pc 0x202.
REQ-036 SHALL cover back-pressure: op_ready low for 5 cycles -> opcode stable, op_valid held, fetch_req ignored; op_ready high -> IDLE next cycle.
REQ-037 SHALL cover wrap: mem[0xFFF]=D1, mem[0x000]=F0, pc 0xFFF -> opcode D1F0, dec_x 1, dec_y F, dec_n 0, next_pc 0x001.
REQ-038 SHALL cover flush in REQ_LO -> IDLE next edge, op_valid never asserted; the following fetch of 0x202 returns the correct opcode.
REQ-039 SHALL cover rst asserted in CAP_LO -> opcode 0000, op_valid 0, fetch_ready 1 after release.
REQ-040 SHALL cover a font read: pc 0x000 -> opcode F090; mem_we observed 0 throughout all scenarios.

Source files
------------

// File: rtl/chip8_fetch.sv
// CHIP-8 opcode fetch: reads two bytes from a 1-cycle registered-read memory and presents a decoded opcode.
// Latency: request accepted at edge k -> op_valid from edge k+3; holds in VALID until op_ready; flush aborts anywhere.
module chip8_fetch #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              fetch_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [15:0]       opcode,
  output logic [ADDR_W-1:0] op_pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic [3:0]        dec_x,
  output logic [3:0]        dec_y,
  output logic [3:0]        dec_n,
  output logic [7:0]        dec_nn,
  output logic [11:0]       dec_nnn,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_HI = 3'd1,
    REQ_LO = 3'd2,
    CAP_LO = 3'd3,
    VALID  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Each byte is captured one state after its address is presented, matching the memory's read latency.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_req) begin
            pc_d    = pc_in;
            state_d = REQ_HI;
          end
        end
        REQ_HI: state_d = REQ_LO;
        REQ_LO: begin
          hi_d    = mem_rdata;
          state_d = CAP_LO;
        end
        CAP_LO: begin
          lo_d    = mem_rdata;
          state_d = VALID;
        end
        VALID: begin
          if (op_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    if (state_q == REQ_LO || state_q == CAP_LO) mem_addr = pc_q + ADDR_W'(1);
    else                                         mem_addr = pc_q;
  end

  assign mem_we      = 1'b0;
  assign mem_wdata   = 8'h00;
  assign fetch_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign op_valid    = (state_q == VALID);
  assign opcode      = {hi_q, lo_q};
  assign op_pc       = pc_q;
  assign next_pc     = pc_q + ADDR_W'(2);
  assign dec_x       = opcode[11:8];
  assign dec_y       = opcode[7:4];
  assign dec_n       = opcode[3:0];
  assign dec_nn      = opcode[7:0];
  assign dec_nnn     = opcode[11:0];

endmodule

// File: tb/tb_chip8_fetch.sv
// Directed bench for chip8_fetch with a behavioural 1-cycle registered-read memory.
module tb_chip8_fetch;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic          fetch_ready;
  logic          flush = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [15:0]   opcode;
  logic [AW-1:0] op_pc, next_pc;
  logic [3:0]    dec_x, dec_y, dec_n;
  logic [7:0]    dec_nn;
  logic [11:0]   dec_nnn;
  logic          busy;

  logic [7:0] mem [0:4095];
  int n_vec = 0;
  int n_err = 0;

  chip8_fetch #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_in(pc_in),
    .fetch_ready(fetch_ready), .flush(flush), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .op_pc(op_pc), .next_pc(next_pc), .dec_x(dec_x), .dec_y(dec_y),
    .dec_n(dec_n), .dec_nn(dec_nn), .dec_nnn(dec_nnn), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  // Write port must stay idle in every scenario.
  always @(negedge clk) begin
    n_vec++;
    if (mem_we !== 1'b0 || mem_wdata !== 8'h00) begin
      n_err++;
      $display("FAIL mem_we_idle: we=%b wdata=%h, required 0/00", mem_we, mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] pc);
    pc_in     = pc;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL rst_op_valid: got %b, required 0", op_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_vec++; if (opcode !== 16'h0000) begin n_err++; $display("FAIL rst_opcode: got %h, required 0000", opcode); end
    n_vec++; if (op_pc !== 12'h000) begin n_err++; $display("FAIL rst_pc: got %h, required 000", op_pc); end
    rst = 1'b0;
    tick();
    n_vec++; if (fetch_ready !== 1'b1) begin n_err++; $display("FAIL rst_fetch_ready: got %b, required 1", fetch_ready); end
  endtask

  task automatic test_basic();
    start(12'h200);
    n_vec++; if (busy !== 1'b1 || fetch_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy: busy=%b rdy=%b, required 1/0", busy, fetch_ready); end
    n_vec++; if (mem_addr !== 12'h200) begin n_err++; $display("FAIL basic_addr_hi: got %h, required 200", mem_addr); end
    n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat_k: op_valid=%b, required 0", op_valid); end
    tick();
    n_vec++; if (mem_addr !== 12'h201) begin n_err++; $display("FAIL basic_addr_lo: got %h, required 201", mem_addr); end
    n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat_k1: op_valid=%b, required 0", op_valid); end
    tick();
    n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat_k2: op_valid=%b, required 0", op_valid); end
    tick();
    n_vec++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL basic_lat_k3: op_valid=%b, required 1", op_valid); end
    n_vec++; if (opcode !== 16'h1234) begin n_err++; $display("FAIL basic_opcode: got %h, required 1234", opcode); end
    n_vec++; if (dec_nnn !== 12'h234) begin n_err++; $display("FAIL basic_nnn: got %h, required 234", dec_nnn); end
    n_vec++; if (dec_nn !== 8'h34 || dec_x !== 4'h2) begin n_err++; $display("FAIL basic_nn_x: nn=%h x=%h, required 34/2", dec_nn, dec_x); end
    n_vec++; if (op_pc !== 12'h200 || next_pc !== 12'h202) begin n_err++; $display("FAIL basic_pc: op_pc=%h next=%h, required 200/202", op_pc, next_pc); end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    n_vec++; if (op_valid !== 1'b0 || fetch_ready !== 1'b1) begin n_err++; $display("FAIL basic_handshake: valid=%b rdy=%b, required 0/1", op_valid, fetch_ready); end
  endtask

  task automatic test_backpressure();
    bit bad = 0;
    start(12'h300);
    for (int i = 0; i < 10 && op_valid !== 1'b1; i++) tick();
    n_vec++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL bp_timeout: op_valid=%b, required 1", op_valid); end
    pc_in     = 12'h400;
    fetch_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (op_valid !== 1'b1 || opcode !== 16'h6A05 || op_pc !== 12'h300) bad = 1;
    end
    n_vec++; if (bad) begin n_err++; $display("FAIL bp_hold: valid=%b opcode=%h pc=%h, required 1/6a05/300", op_valid, opcode, op_pc); end
    fetch_req = 1'b0;
    op_ready  = 1'b1;
    tick();
    op_ready  = 1'b0;
    n_vec++; if (op_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_release: valid=%b busy=%b, required 0/0", op_valid, busy); end
    n_vec++; if (op_pc !== 12'h300) begin n_err++; $display("FAIL bp_ignored_req: op_pc=%h, required 300", op_pc); end
  endtask

  task automatic test_wrap();
    start(12'hFFF);
    for (int i = 0; i < 10 && op_valid !== 1'b1; i++) tick();
    n_vec++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL wrap_timeout: op_valid=%b, required 1", op_valid); end
    n_vec++; if (opcode !== 16'hD1F0) begin n_err++; $display("FAIL wrap_opcode: got %h, required d1f0", opcode); end
    n_vec++; if (dec_x !== 4'h1 || dec_y !== 4'hF || dec_n !== 4'h0) begin n_err++; $display("FAIL wrap_dec: x=%h y=%h n=%h, required 1/f/0", dec_x, dec_y, dec_n); end
    n_vec++; if (next_pc !== 12'h001 || op_pc !== 12'hFFF) begin n_err++; $display("FAIL wrap_pc: next=%h op_pc=%h, required 001/fff", next_pc, op_pc); end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic test_flush();
    bit seen = 0;
    start(12'h500);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (fetch_ready !== 1'b1 || busy !== 1'b0 || op_valid !== 1'b0) begin n_err++; $display("FAIL flush_idle: rdy=%b busy=%b valid=%b, required 1/0/0", fetch_ready, busy, op_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (op_valid !== 1'b0) seen = 1;
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL flush_no_valid: op_valid seen=1, required 0"); end
    start(12'h202);
    for (int i = 0; i < 10 && op_valid !== 1'b1; i++) tick();
    n_vec++; if (op_valid !== 1'b1 || opcode !== 16'hA2F0) begin n_err++; $display("FAIL flush_refetch: valid=%b opcode=%h, required 1/a2f0", op_valid, opcode); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (op_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL flush_valid: valid=%b busy=%b, required 0/0", op_valid, busy); end
    pc_in     = 12'h600;
    fetch_req = 1'b1;
    flush     = 1'b1;
    tick();
    fetch_req = 1'b0;
    flush     = 1'b0;
    n_vec++; if (busy !== 1'b0 || op_pc !== 12'h202) begin n_err++; $display("FAIL flush_over_req: busy=%b op_pc=%h, required 0/202", busy, op_pc); end
  endtask

  task automatic test_reset_mid();
    start(12'h200);
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_vec++; if (opcode !== 16'h0000 || op_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_state: opcode=%h valid=%b busy=%b, required 0000/0/0", opcode, op_valid, busy); end
    n_vec++; if (op_pc !== 12'h000) begin n_err++; $display("FAIL rstmid_pc: got %h, required 000", op_pc); end
    rst = 1'b0;
    tick();
    n_vec++; if (fetch_ready !== 1'b1 || opcode !== 16'h0000) begin n_err++; $display("FAIL rstmid_release: rdy=%b opcode=%h, required 1/0000", fetch_ready, opcode); end
  endtask

  task automatic test_font();
    start(12'h000);
    for (int i = 0; i < 10 && op_valid !== 1'b1; i++) tick();
    n_vec++; if (op_valid !== 1'b1 || opcode !== 16'hF090) begin n_err++; $display("FAIL font_opcode: valid=%b opcode=%h, required 1/f090", op_valid, opcode); end
    n_vec++; if (next_pc !== 12'h002) begin n_err++; $display("FAIL font_next_pc: got %h, required 002", next_pc); end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL font_handshake: op_valid=%b, required 0", op_valid); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h000] = 8'hF0; mem[12'h001] = 8'h90;
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    mem[12'h202] = 8'hA2; mem[12'h203] = 8'hF0;
    mem[12'h300] = 8'h6A; mem[12'h301] = 8'h05;
    mem[12'h500] = 8'h11; mem[12'h501] = 8'h22;
    mem[12'hFFF] = 8'hD1;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_font();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
